// File: rtl/lsu_mem_master.sv
// Load/store initiator for the byte-masked single-port memory.
// One RV32I request in flight; lane shifting on stores, extension on loads.
module lsu_mem_master #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_w_data,
  output logic [3:0]        mem_masking,
  output logic              mem_we_re,
  input  logic [31:0]       mem_r_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        funct3_q;
  logic              we_q;

  logic accept;
  logic bad_f3;
  logic misal;
  logic req_bad;
  logic unused_addr;

  // Address bits above the memory depth wrap and are never stored.
  assign unused_addr = ^req_addr[31:ADDR_W+2];

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    bad_f3 = 1'b0;
    misal  = 1'b0;
    if (req_we) begin
      bad_f3 = (req_funct3 > 3'd2);
    end else begin
      bad_f3 = (req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11);
    end
    unique case (req_funct3[1:0])
      2'd1:    misal = req_addr[0];
      2'd2:    misal = (req_addr[1:0] != 2'd0);
      default: misal = 1'b0;
    endcase
    req_bad = bad_f3 || misal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q   <= req_addr[ADDR_W+1:0];
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            we_q     <= req_we;
            if (req_bad)     state <= S_ERR;
            else if (req_we) state <= S_WRITE;
            else             state <= S_READ;
          end
        end
        S_WRITE: state <= S_DONE;
        S_READ:  state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [31:0] st_data;
  logic [3:0]  st_mask;

  always_comb begin
    st_data = wdata_q;
    st_mask = 4'b1111;
    unique case (funct3_q[1:0])
      2'd0: begin
        st_data = {4{wdata_q[7:0]}};
        st_mask = 4'b0001 << addr_q[1:0];
      end
      2'd1: begin
        st_data = {2{wdata_q[15:0]}};
        st_mask = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = wdata_q;
        st_mask = 4'b1111;
      end
    endcase
  end

  assign mem_address = addr_q[ADDR_W+1:2];
  assign mem_w_data  = st_data;
  assign mem_we_re   = (state == S_WRITE);
  assign mem_masking = (state == S_WRITE) ? st_mask : 4'b0000;

  logic [7:0]  rb;
  logic [15:0] rh;
  logic [31:0] ld;

  always_comb begin
    rb = mem_r_data[{addr_q[1:0], 3'b000} +: 8];
    rh = mem_r_data[{addr_q[1], 4'b0000} +: 16];
    unique case (funct3_q)
      3'd0:    ld = {{24{rb[7]}}, rb};
      3'd1:    ld = {{16{rh[15]}}, rh};
      3'd4:    ld = {24'h0, rb};
      3'd5:    ld = {16'h0, rh};
      default: ld = mem_r_data;
    endcase
  end

  assign resp_valid = (state == S_DONE) || (state == S_ERR);
  assign resp_err   = (state == S_ERR);
  assign resp_rdata = (state == S_DONE && !we_q) ? ld : 32'h0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: behavioural memory plus a byte-level
// reference model driving directed and random load/store traffic.
module tb_lsu_mem_master;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'd0;
  logic [31:0]       req_addr = 32'h0;
  logic [31:0]       req_wdata = 32'h0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_w_data;
  logic [3:0]        mem_masking;
  logic              mem_we_re;
  logic [31:0]       mem_r_data = 32'h0;

  logic [31:0] mem [0:255] = '{default: 32'h0};
  logic [7:0]  ref_b [0:1023] = '{default: 8'h0};

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lsu_mem_master #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_address(mem_address), .mem_w_data(mem_w_data),
    .mem_masking(mem_masking), .mem_we_re(mem_we_re),
    .mem_r_data(mem_r_data)
  );

  // Single-port memory: masked write or registered read each edge.
  always @(posedge clk) begin
    if (mem_we_re) begin
      for (int i = 0; i < 4; i++)
        if (mem_masking[i]) mem[mem_address][8*i +: 8] <= mem_w_data[8*i +: 8];
    end else begin
      mem_r_data <= mem[mem_address];
    end
  end

  function automatic int m_n(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit m_err(input bit we, input logic [2:0] f3,
                               input logic [31:0] a);
    bit ill;
    int n;
    if (we) ill = (f3 > 3'd2);
    else    ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    n = m_n(f3);
    return ill || ((a % n) != 0);
  endfunction

  function automatic int bidx(input logic [31:0] a, input int k);
    return ((a / 4) % 256) * 4 + (a % 4) + k;
  endfunction

  task automatic do_req(input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input string tag);
    bit e;
    int n, off, w;
    logic [3:0]  xm;
    logic [31:0] xw, xr;
    e = m_err(we, f3, a);
    n = m_n(f3);
    off = int'(a % 4);
    for (int i = 0; i < 4; i++) begin
      xm[i] = (i >= off) && (i < off + n);
      xw[8*i +: 8] = wd[8*(i % n) +: 8];
    end
    xr = 32'h0;
    if (!e && !we) begin
      for (int k = 0; k < n; k++)
        xr = xr | (32'(ref_b[bidx(a, k)]) << (8*k));
      if (!f3[2] && n < 4 && xr[8*n-1])
        xr = xr | ~((32'h1 << (8*n)) - 1);
    end
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_timeout: got %b want 1", tag, req_ready);
    end
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    if (e) begin
      tests++;
      if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin
        fails++;
        $display("FAIL %s err_resp: got v=%b e=%b want v=1 e=1",
                 tag, resp_valid, resp_err);
      end
      tests++;
      if (resp_rdata !== 32'h0 || mem_we_re !== 1'b0 || mem_masking !== 4'h0) begin
        fails++;
        $display("FAIL %s err_side: got rdata=%h we=%b mask=%b want 0/0/0",
                 tag, resp_rdata, mem_we_re, mem_masking);
      end
    end else begin
      tests++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s busy: got v=%b rdy=%b want 0/0",
                 tag, resp_valid, req_ready);
      end
      tests++;
      if (mem_we_re !== we || mem_address !== 8'((a / 4) % 256)) begin
        fails++;
        $display("FAIL %s mem_cmd: got we=%b addr=%h want we=%b addr=%h",
                 tag, mem_we_re, mem_address, we, 8'((a / 4) % 256));
      end
      if (we) begin
        tests++;
        if (mem_masking !== xm || mem_w_data !== xw) begin
          fails++;
          $display("FAIL %s lanes: got mask=%b data=%h want mask=%b data=%h",
                   tag, mem_masking, mem_w_data, xm, xw);
        end
        for (int k = 0; k < n; k++) ref_b[bidx(a, k)] = wd[8*k +: 8];
      end
      @(negedge clk);
      tests++;
      if (resp_valid !== 1'b1 || resp_err !== 1'b0 || mem_we_re !== 1'b0) begin
        fails++;
        $display("FAIL %s done: got v=%b e=%b we=%b want 1/0/0",
                 tag, resp_valid, resp_err, mem_we_re);
      end
      tests++;
      if (resp_rdata !== xr) begin
        fails++;
        $display("FAIL %s rdata: got %h want %h", tag, resp_rdata, xr);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_hs: got rdy=%b v=%b e=%b want 1/0/0",
               req_ready, resp_valid, resp_err);
    end
    tests++;
    if (resp_rdata !== 32'h0 || mem_we_re !== 1'b0 || mem_masking !== 4'h0) begin
      fails++;
      $display("FAIL reset_mem: got rdata=%h we=%b mask=%b want 0/0/0",
               resp_rdata, mem_we_re, mem_masking);
    end
    tests++;
    if (mem_address !== 8'h0 || mem_w_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_addr: got addr=%h wd=%h want 0/0",
               mem_address, mem_w_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "sw10");
    do_req(1'b0, 3'd2, 32'h10, 32'h0, "lw10");
    do_req(1'b1, 3'd0, 32'h13, 32'h123456A5, "sb13");
    do_req(1'b0, 3'd0, 32'h13, 32'h0, "lb13");
    do_req(1'b0, 3'd4, 32'h13, 32'h0, "lbu13");
    do_req(1'b1, 3'd1, 32'h22, 32'hCAFE8001, "sh22");
    do_req(1'b0, 3'd1, 32'h22, 32'h0, "lh22");
    do_req(1'b0, 3'd5, 32'h22, 32'h0, "lhu22");
    do_req(1'b0, 3'd2, 32'h20, 32'h0, "lw20");
  endtask

  task automatic test_errors();
    do_req(1'b0, 3'd2, 32'h06, 32'h0, "lw06");
    do_req(1'b1, 3'd1, 32'h05, 32'hFFFF, "sh05");
    do_req(1'b1, 3'd2, 32'h12, 32'h11111111, "sw12");
    do_req(1'b0, 3'd3, 32'h10, 32'h0, "ld_f3");
    do_req(1'b0, 3'd7, 32'h10, 32'h0, "ld_f7");
    do_req(1'b1, 3'd4, 32'h10, 32'h77777777, "st_f4");
    do_req(1'b0, 3'd2, 32'h04, 32'h0, "lw04_after");
    do_req(1'b0, 3'd2, 32'h10, 32'h0, "lw10_after");
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      bit we;
      logic [2:0] f3;
      logic [31:0] a;
      we = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom & 32'hFFFF_F03F;
      do_req(we, f3, a, $urandom, "rand");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    d = $urandom;
    @(negedge clk);
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = d;
    req_valid = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      tests++;
      if (req_ready !== (k % 3 == 0) || resp_valid !== (k % 3 == 2)) begin
        fails++;
        $display("FAIL b2b_%0d: got rdy=%b v=%b want rdy=%b v=%b", k,
                 req_ready, resp_valid, k % 3 == 0, k % 3 == 2);
      end
    end
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) ref_b[bidx(32'h40, k)] = d[8*k +: 8];
    do_req(1'b0, 3'd2, 32'h40, 32'h0, "b2b_rd");
  endtask

  task automatic rst_mid(input bit we, input logic [31:0] a,
                         input logic [31:0] wd, input string tag);
    @(negedge clk);
    @(negedge clk);
    req_we = we; req_funct3 = we ? 3'd0 : 3'd2;
    req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (we) ref_b[bidx(a, 0)] = wd[7:0];
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        fails++;
        $display("FAIL %s_%0d: got v=%b rdy=%b want 0/1",
                 tag, k, resp_valid, req_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    rst_mid(1'b0, 32'h40, 32'h0, "rst_read");
    rst_mid(1'b1, 32'h31, 32'h0000005A, "rst_write");
    tests++;
    if (mem[12][15:8] !== 8'h5A) begin
      fails++;
      $display("FAIL rst_write_mem: got %h want 5a", mem[12][15:8]);
    end
    do_req(1'b0, 3'd4, 32'h31, 32'h0, "rst_write_lbu");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
